// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising/falling edge detector that holds each
// detected edge as a pending event and hands pending events round-robin to one
// valid/ready event port, counting events lost when a channel re-fires before
// its previous event has left the pending store.
module edge_event_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         sig_i,
    input  logic [NCH-1:0]         rise_en_i,
    input  logic [NCH-1:0]         fall_en_i,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [$clog2(NCH)-1:0] evt_ch_o,
    output logic                   evt_rise_o,
    output logic                   ovf_o,
    output logic [CW-1:0]          ovf_cnt_o,
    input  logic                   clr_ovf_i
);
    localparam int CHW  = $clog2(NCH);
    localparam int CNTW = $clog2(NCH + 1);
    localparam int SUMW = CW + CNTW;

    typedef enum logic { ARM = 1'b0, RUN = 1'b1 } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  prev_q, prev_d;
    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  ptype_q, ptype_d;
    logic            evt_valid_q, evt_valid_d;
    logic [CHW-1:0]  evt_ch_q, evt_ch_d;
    logic            evt_rise_q, evt_rise_d;
    logic [CHW-1:0]  last_grant_q, last_grant_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic            run;
    logic [NCH-1:0]  rise_det, fall_det, edge_det;
    logic            slot_free;
    logic            grant_vld;
    logic [CHW-1:0]  grant_ch;
    logic [CHW:0]    idx;
    logic [NCH-1:0]  load_vec;
    logic [NCH-1:0]  drop_vec;
    logic [CNTW-1:0] drop_cnt;

    // Add a per-cycle drop count to the overflow counter, sticking at all-ones.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0]   base,
                                              input logic [CNTW-1:0] inc);
        logic [SUMW-1:0] sum;
        sum = {{CNTW{1'b0}}, base} + {{CW{1'b0}}, inc};
        if (|sum[SUMW-1:CW]) begin
            return {CW{1'b1}};
        end
        return sum[CW-1:0];
    endfunction

    // Edge detection against last cycle's sample; nothing fires while arming.
    always_comb begin
        run      = (state_q == RUN);
        rise_det = {NCH{run}} & sig_i & ~prev_q & rise_en_i;
        fall_det = {NCH{run}} & ~sig_i & prev_q & fall_en_i;
        edge_det = rise_det | fall_det;
    end

    // Round-robin grant over pending channels, starting just after the last winner.
    always_comb begin
        slot_free = ~evt_valid_q | evt_ready_i;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        if (slot_free) begin
            for (int i = 1; i <= NCH; i++) begin
                idx = {1'b0, last_grant_q} + (CHW+1)'(i);
                if (idx >= (CHW+1)'(NCH)) begin
                    idx = idx - (CHW+1)'(NCH);
                end
                if (!grant_vld && pend_q[idx[CHW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_ch  = idx[CHW-1:0];
                end
            end
        end
        load_vec = '0;
        if (grant_vld) begin
            load_vec[grant_ch] = 1'b1;
        end
    end

    // Pending store update: a channel being moved into the slot can take a fresh
    // edge in the same cycle; otherwise a second edge on a busy channel is lost.
    always_comb begin
        pend_d   = pend_q;
        ptype_d  = ptype_q;
        drop_vec = '0;
        drop_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            if (load_vec[c]) begin
                pend_d[c] = 1'b0;
            end
            if (edge_det[c]) begin
                if (load_vec[c] || !pend_q[c]) begin
                    pend_d[c]  = 1'b1;
                    ptype_d[c] = rise_det[c];
                end else begin
                    drop_vec[c] = 1'b1;
                end
            end
            drop_cnt = drop_cnt + CNTW'(drop_vec[c]);
        end
    end

    // Event slot: load the granted channel, empty on accept, otherwise hold steady.
    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_ch_d     = evt_ch_q;
        evt_rise_d   = evt_rise_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            evt_valid_d  = 1'b1;
            evt_ch_d     = grant_ch;
            evt_rise_d   = ptype_q[grant_ch];
            last_grant_d = grant_ch;
        end else if (slot_free) begin
            evt_valid_d = 1'b0;
        end
    end

    // Overflow flag and counter; a clear still lets this cycle's drops register.
    always_comb begin
        ovf_d     = clr_ovf_i ? 1'b0 : ovf_q;
        ovf_cnt_d = clr_ovf_i ? '0   : ovf_cnt_q;
        if (|drop_vec) begin
            ovf_d = 1'b1;
        end
        ovf_cnt_d = sat_add(ovf_cnt_d, drop_cnt);
    end

    // Sequencing: one arming cycle after reset loads prev so a level already high
    // at reset release is not mistaken for an edge.
    always_comb begin
        prev_d  = sig_i;
        state_d = state_q;
        case (state_q)
            ARM:     state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = ARM;
        endcase
    end

    // State registers; reset discards all pending and in-slot events at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARM;
            prev_q       <= '0;
            pend_q       <= '0;
            ptype_q      <= '0;
            evt_valid_q  <= 1'b0;
            evt_ch_q     <= '0;
            evt_rise_q   <= 1'b0;
            last_grant_q <= CHW'(NCH - 1);
            ovf_q        <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pend_q       <= pend_d;
            ptype_q      <= ptype_d;
            evt_valid_q  <= evt_valid_d;
            evt_ch_q     <= evt_ch_d;
            evt_rise_q   <= evt_rise_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;
    assign evt_rise_o  = evt_rise_q;
    assign ovf_o       = ovf_q;
    assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: a table of hand-computed vectors, a few
// multi-cycle corner sequences, and randomized traffic against a reference model.
module tb_edge_event_arbiter;
    localparam int NCH    = 4;
    localparam int CW     = 8;
    localparam int MAXCNT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  sig;
    logic [NCH-1:0]  ren;
    logic [NCH-1:0]  fen;
    logic            rdy;
    logic            clr;
    logic            evt_valid_o;
    logic [1:0]      evt_ch_o;
    logic            evt_rise_o;
    logic            ovf_o;
    logic [CW-1:0]   ovf_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit m_arm;
    bit m_prev  [NCH];
    bit m_pend  [NCH];
    bit m_ptype [NCH];
    bit m_valid;
    int m_ch;
    bit m_rise;
    int m_last;
    bit m_ovf;
    int m_cnt;

    typedef struct {
        logic [3:0] sig;
        logic [3:0] ren;
        logic [3:0] fen;
        logic       rdy;
        logic       ev;
        logic [1:0] ech;
        logic       erise;
    } vec_t;

    vec_t vecs [15];

    edge_event_arbiter #(.NCH(NCH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_i       (sig),
        .rise_en_i   (ren),
        .fall_en_i   (fen),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (rdy),
        .evt_ch_o    (evt_ch_o),
        .evt_rise_o  (evt_rise_o),
        .ovf_o       (ovf_o),
        .ovf_cnt_o   (ovf_cnt_o),
        .clr_ovf_i   (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_arm   = 1'b1;
        m_valid = 1'b0;
        m_ch    = 0;
        m_rise  = 1'b0;
        m_last  = NCH - 1;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        for (int c = 0; c < NCH; c++) begin
            m_prev[c]  = 1'b0;
            m_pend[c]  = 1'b0;
            m_ptype[c] = 1'b0;
        end
    endtask

    // One clock of the behaviour, computed from the current inputs.
    task automatic model_step();
        int g;
        int drops;
        bit free;
        bit r;
        bit f;
        bit n_pend  [NCH];
        bit n_ptype [NCH];
        free = !m_valid || rdy;
        g    = -1;
        if (free) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (m_pend[c] && g < 0) g = c;
            end
        end
        drops = 0;
        for (int c = 0; c < NCH; c++) begin
            r = !m_arm && sig[c] && !m_prev[c] && ren[c];
            f = !m_arm && !sig[c] && m_prev[c] && fen[c];
            n_pend[c]  = (c == g) ? 1'b0 : m_pend[c];
            n_ptype[c] = m_ptype[c];
            if (r || f) begin
                if (c == g || !m_pend[c]) begin
                    n_pend[c]  = 1'b1;
                    n_ptype[c] = r;
                end else begin
                    drops++;
                end
            end
            m_prev[c] = sig[c];
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (drops > 0) m_ovf = 1'b1;
        m_cnt = m_cnt + drops;
        if (m_cnt > MAXCNT) m_cnt = MAXCNT;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_ch    = g;
            m_rise  = m_ptype[g];
            m_last  = g;
        end else if (free) begin
            m_valid = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            m_pend[c]  = n_pend[c];
            m_ptype[c] = n_ptype[c];
        end
        m_arm = 1'b0;
    endtask

    task automatic compare_model();
        check("mdl_valid", int'(evt_valid_o), int'(m_valid));
        if (m_valid) begin
            check("mdl_ch", int'(evt_ch_o), m_ch);
            check("mdl_rise", int'(evt_rise_o), int'(m_rise));
        end
        check("mdl_ovf", int'(ovf_o), int'(m_ovf));
        check("mdl_cnt", int'(ovf_cnt_o), m_cnt);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        if (!rst) begin
            @(posedge clk);
            #1;
            model_reset();
        end else begin
            model_step();
            @(posedge clk);
            #1;
        end
        compare_model();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_valid", int'(evt_valid_o), 0);
        check("rst_ch", int'(evt_ch_o), 0);
        check("rst_rise", int'(evt_rise_o), 0);
        check("rst_ovf", int'(ovf_o), 0);
        check("rst_cnt", int'(ovf_cnt_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        sig = '0;
        ren = 4'hF;
        fen = 4'h0;
        rdy = 1'b1;
        clr = 1'b0;

        // sig, rise_en, fall_en, ready, expected valid, ch, rise
        vecs[0]  = '{4'b0000, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[3]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1};
        vecs[4]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1};
        vecs[5]  = '{4'b0000, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[8]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1};
        vecs[9]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1};
        vecs[10] = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{4'b0100, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{4'b0100, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1};
        vecs[13] = '{4'b0100, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{4'b0100, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};

        #2;
        apply_reset();

        // table: burst ordering after reset, repeat burst, then a single channel
        for (int i = 0; i < 15; i++) begin
            sig = vecs[i].sig;
            ren = vecs[i].ren;
            fen = vecs[i].fen;
            rdy = vecs[i].rdy;
            tick();
            check($sformatf("tbl%0d_valid", i), int'(evt_valid_o), int'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("tbl%0d_ch", i), int'(evt_ch_o), int'(vecs[i].ech));
                check($sformatf("tbl%0d_rise", i), int'(evt_rise_o), int'(vecs[i].erise));
            end
            check($sformatf("tbl%0d_ovf", i), int'(ovf_o), 0);
        end

        // level already high across reset release never produces an event
        sig = 4'b0001;
        ren = 4'hF;
        fen = 4'hF;
        rdy = 1'b1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("arm_valid", int'(evt_valid_o), 0);
        end

        // rise, fall, rise on channel 1 while the consumer stalls
        sig = 4'b0000;
        rdy = 1'b0;
        apply_reset();
        tick();
        sig = 4'b0010;
        tick();
        check("tog_v1", int'(evt_valid_o), 0);
        sig = 4'b0000;
        tick();
        check("tog_v2", int'(evt_valid_o), 1);
        check("tog_ch2", int'(evt_ch_o), 1);
        check("tog_ovf2", int'(ovf_o), 0);
        sig = 4'b0010;
        tick();
        check("tog_ch3", int'(evt_ch_o), 1);
        check("tog_rise3", int'(evt_rise_o), 1);
        check("tog_ovf3", int'(ovf_o), 1);
        check("tog_cnt3", int'(ovf_cnt_o), 1);
        rdy = 1'b1;
        tick();
        check("tog_v4", int'(evt_valid_o), 1);
        check("tog_ch4", int'(evt_ch_o), 1);
        check("tog_rise4", int'(evt_rise_o), 0);
        tick();
        check("tog_v5", int'(evt_valid_o), 0);
        check("tog_cnt5", int'(ovf_cnt_o), 1);

        // counter saturation, clear, and clear coinciding with a drop
        sig = 4'b0000;
        rdy = 1'b0;
        apply_reset();
        tick();
        for (int i = 0; i < 80; i++) begin
            sig = ~sig;
            tick();
        end
        check("sat_cnt", int'(ovf_cnt_o), MAXCNT);
        check("sat_ovf", int'(ovf_o), 1);
        clr = 1'b1;
        tick();
        check("clr_cnt", int'(ovf_cnt_o), 0);
        check("clr_ovf", int'(ovf_o), 0);
        sig[1] = ~sig[1];
        tick();
        check("clrdrop_cnt", int'(ovf_cnt_o), 1);
        check("clrdrop_ovf", int'(ovf_o), 1);
        clr = 1'b0;
        tick();

        // reset in the middle of a burst discards everything
        sig = 4'b0000;
        rdy = 1'b0;
        apply_reset();
        tick();
        sig = 4'b1011;
        tick();
        tick();
        check("mid_v_before", int'(evt_valid_o), 1);
        rdy = 1'b1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_v_after", int'(evt_valid_o), 0);
        end

        // randomized traffic
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            sig = 4'($urandom);
            ren = 4'($urandom);
            fen = 4'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
